// File: rtl/gcd_engine.sv
// gcd_engine: start/done GCD unit, Euclid subtraction or Stein binary per request.
module gcd_engine #(
  parameter  int unsigned WIDTH = 16,
  localparam int unsigned CW    = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             mode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] gcd,
  output logic             coprime,
  output logic [WIDTH-1:0] cycles
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] ra;
  logic [WIDTH-1:0] rb;
  logic             m;
  logic [CW-1:0]    k;
  logic [WIDTH-1:0] cnt;

  logic [WIDTH-1:0] ra_n;
  logic [WIDTH-1:0] rb_n;
  logic [CW-1:0]    k_n;
  logic [WIDTH-1:0] result;
  logic             fin;
  logic [WIDTH-1:0] cnt_sat;

  // One reduction step: first matching rule wins, terminal rules raise fin.
  always_comb begin
    fin    = 1'b0;
    result = ra;
    ra_n   = ra;
    rb_n   = rb;
    k_n    = k;
    if (rb == '0) begin
      fin    = 1'b1;
      result = ra;
    end else if (ra == '0) begin
      fin    = 1'b1;
      result = rb;
    end else if (ra == rb) begin
      fin    = 1'b1;
      result = ra << k;
    end else if (!m) begin
      if (ra > rb) ra_n = ra - rb;
      else         rb_n = rb - ra;
    end else begin
      if (!ra[0] && !rb[0]) begin
        ra_n = ra >> 1;
        rb_n = rb >> 1;
        k_n  = k + CW'(1);
      end else if (!ra[0]) begin
        ra_n = ra >> 1;
      end else if (!rb[0]) begin
        rb_n = rb >> 1;
      end else if (ra > rb) begin
        ra_n = (ra - rb) >> 1;
      end else begin
        rb_n = (rb - ra) >> 1;
      end
    end
  end

  // Cycle counter increment that sticks at all-ones.
  always_comb begin
    cnt_sat = (cnt == '1) ? cnt : cnt + WIDTH'(1);
  end

  // Control FSM with registered outputs; operands latched only when idle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      ra      <= '0;
      rb      <= '0;
      m       <= 1'b0;
      k       <= '0;
      cnt     <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      gcd     <= '0;
      coprime <= 1'b0;
      cycles  <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            ra    <= a;
            rb    <= b;
            m     <= mode;
            k     <= '0;
            cnt   <= '0;
            busy  <= 1'b1;
            state <= CALC;
          end
        end
        CALC: begin
          cnt <= cnt_sat;
          if (fin) begin
            gcd     <= result;
            coprime <= (result == WIDTH'(1));
            cycles  <= cnt_sat;
            done    <= 1'b1;
            state   <= DONE;
          end else begin
            ra <= ra_n;
            rb <= rb_n;
            k  <= k_n;
          end
        end
        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
